mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one memory op from execute and runs it on a
// simple request/ack bus. Byte lanes are steered here and accesses time out.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        byte_size,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   input  logic [4:0]  rd_i,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [63:0] rdata,
   output logic [4:0]  rd_o,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_be,
   input  logic        bus_ack,
   input  logic [63:0] bus_rdata
);
   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic          lat_byte;
   logic [2:0]    lat_off;

   logic       op_ok, op_bad, misal;
   logic [7:0] ack_byte;

   assign op_ok    = req_valid && (mem_read ^ mem_write);
   assign op_bad   = req_valid && mem_read && mem_write;
   assign misal    = !byte_size && (addr[2:0] != 3'd0);
   assign ack_byte = bus_rdata[{lat_off, 3'b000} +: 8];

   // Stall must assert in the same cycle an op is presented, so it is decoded from inputs.
   assign stall = !reset && ((state == BUS) || ((state == IDLE) && (op_ok || op_bad)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_byte  <= 1'b0;
         lat_off   <= 3'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         rd_o      <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               err <= 1'b0;
               if (op_ok || op_bad) begin
                  rd_o     <= rd_i;
                  lat_byte <= byte_size;
                  lat_off  <= addr[2:0];
                  rdata    <= '0;
                  wait_cnt <= '0;
                  if (op_bad || misal) begin
                     state <= RESP;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state     <= BUS;
                     bus_req   <= 1'b1;
                     bus_we    <= mem_write;
                     bus_addr  <= {addr[63:3], 3'b000};
                     bus_be    <= byte_size ? (8'b1 << addr[2:0]) : 8'hFF;
                     bus_wdata <= byte_size ? {8{wdata[7:0]}} : wdata;
                  end
               end
            end
            BUS: begin
               // An ack in the final wait cycle still wins over the timeout.
               if (bus_ack || (wait_cnt == LAST)) begin
                  state   <= RESP;
                  done    <= 1'b1;
                  err     <= !bus_ack;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (bus_ack && !bus_we)
                     rdata <= lat_byte ? {56'd0, ack_byte} : bus_rdata;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
               err   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
